mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Two modes:
  - static: the external select chooses the channel.
  - scan: the block steps through all channels itself, holding each one for DWELL cycles.
- Successor to the fixed 4:1 combinational mux. Adds width/channel generalisation, a registered output with a valid flag, out-of-range detection and an autonomous scanner.
- Used to time-share one output path across several sources.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 1, data width per channel in bits.
- SEL_W, 2, select/pointer width; must satisfy 2**SEL_W >= N_CH.
- DWELL, 5, cycles each channel is presented in scan mode (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- d  in  N_CH*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- sel  in  SEL_W  channel select; in static mode it picks the channel, in scan mode it sets the start channel.
- mode  in  1  0 = static, 1 = scan.
- en  in  1  clock enable for the whole datapath.
- f  out  W  registered selected data.
- ch  out  SEL_W  index of the channel currently driving f.
- valid  out  1  f/ch are meaningful this cycle.
- wrap  out  1  one-cycle pulse when scan moves from channel N_CH-1 to 0.

Behaviour:
- Reset (async, rst=1): f=0, ch=0, valid=0, wrap=0, dwell counter=0, scan pointer=0, state=IDLE. All outputs are held while rst=1. Reset asserted mid-scan aborts immediately; there is no partial state afterwards.
- State machine: IDLE, STATIC, SCAN.
  - Any state with en=0 -> IDLE. In IDLE: valid=0, wrap=0, f/ch hold their last values, counter and pointer frozen.
  - IDLE, en=1, mode=0 -> STATIC.
  - IDLE, en=1, mode=1 -> SCAN. The pointer resumes from its frozen value.
  - STATIC -> SCAN when mode rises: pointer<=sel, counter<=0.
  - SCAN -> STATIC when mode falls: static selection applies from that same edge.
- STATIC, each edge with en=1:
  - Latency 1 cycle: f<=d[sel], ch<=sel, valid<=1, wrap<=0.
  - sel >= N_CH (out of range): f<=0, ch<=sel, valid<=0.
- SCAN, each edge with en=1:
  - f<=d[ptr], ch<=ptr, valid<=1. Data is resampled every cycle, so input changes propagate with 1-cycle latency even within a dwell period.
  - counter<DWELL-1: counter<=counter+1, wrap<=0.
  - counter==DWELL-1: counter<=0 and ptr advances. If ptr==N_CH-1 then ptr<=0 and wrap<=1 for exactly one cycle; otherwise ptr<=ptr+1.
  - Entry with sel >= N_CH: pointer loads 0, not sel.
  - DWELL=1: the channel changes every cycle, and wrap pulses once every N_CH cycles.
- Simultaneous mode change and en=0: en=0 wins (state goes to IDLE, nothing updates). The mode change takes effect on the first edge with en=1.
- Widths:
  - ptr and ch are SEL_W bits; no arithmetic overflow beyond N_CH-1 is permitted.
  - counter is 8 bits.
  - No combinational path from any input to any output.

Test Plan:
- Reset: rst=1 for 3 cycles with arbitrary d/sel -> f=0, ch=0, valid=0, wrap=0. Assert rst asynchronously mid-cycle -> outputs clear before the next clk edge.
- Static select (N_CH=4, W=1, d=4'b1010, en=1, mode=0): sel sweeps 0,1,2,3 -> f=0,1,0,1 one cycle after each sel change, ch follows sel, valid=1. Invert d to 4'b0101 -> f inverts on the next edge.
- Out of range (N_CH=3, SEL_W=2): sel=3 -> valid=0, f=0. sel=2 -> valid=1, f=d[2] on the next edge.
- Scan (N_CH=4, DWELL=5, sel=1, mode rises): ch=1 for 5 cycles, then 2, 3, 0. wrap=1 only in the first cycle ch=0. f tracks d[ch] each cycle.
- Enable freeze: en=0 for 7 cycles in the middle of channel 2's dwell (after 2 cycles) -> valid=0, f/ch hold. en=1 -> 3 more cycles on channel 2, then channel 3.
- Mode switch: scan running at ch=3, mode=0 with sel=0 -> next edge ch=0, f=d[0], wrap=0. Then DWELL=1 scan -> ch cycles 0,1,2,3,0 with wrap pulses every 4 cycles.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer with a static-select mode and an
// autonomous scan mode that holds each channel for DWELL cycles.
module mux_scan_n #(
  parameter int N_CH  = 4,
  parameter int W     = 1,
  parameter int SEL_W = 2,
  parameter int DWELL = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] d,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      f,
  output logic [SEL_W-1:0]  ch,
  output logic              valid,
  output logic              wrap
);

  typedef enum logic [1:0] {IDLE, STATIC, SCAN} state_t;

  localparam logic [SEL_W:0]   NCH_L   = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [7:0]       DW_LAST = 8'(DWELL - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [W-1:0]     f_nxt;
  logic [SEL_W-1:0] ch_nxt;
  logic             valid_nxt, wrap_nxt;
  logic             sel_ok;
  logic [SEL_W-1:0] start;

  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] dv,
                                        input logic [SEL_W-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++)
      if (idx == SEL_W'(k)) r = dv[k*W +: W];
    return r;
  endfunction

  assign sel_ok = ({1'b0, sel} < NCH_L);
  assign start  = sel_ok ? sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // en=0 always wins; otherwise mode alone picks the active state.
  always_comb begin
    state_nxt = state;
    if (!en)       state_nxt = IDLE;
    else if (!mode) state_nxt = STATIC;
    else           state_nxt = SCAN;
  end

  always_comb begin
    f_nxt     = f;
    ch_nxt    = ch;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    if (en) begin
      if (!mode) begin
        f_nxt     = sel_ok ? pick(d, sel) : '0;
        ch_nxt    = sel;
        valid_nxt = sel_ok;
      end else if (state == STATIC) begin
        // Entry edge presents the start channel and counts as the first dwell cycle.
        ptr_nxt   = start;
        cnt_nxt   = '0;
        f_nxt     = pick(d, start);
        ch_nxt    = start;
        valid_nxt = 1'b1;
      end else begin
        if (cnt >= DW_LAST) begin
          cnt_nxt = '0;
          if (ptr >= LAST_CH) begin
            ptr_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
        f_nxt     = pick(d, ptr_nxt);
        ch_nxt    = ptr_nxt;
        valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      f     <= f_nxt;
      ch    <= ch_nxt;
      valid <= valid_nxt;
      wrap  <= wrap_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: three configurations driven by shared controls,
// directed tables/sequences plus random stimulus against a phase-based model.
module tb_mux_scan_n;

  logic        clk, rst, mode, en;
  logic [1:0]  sel;
  logic [63:0] dv [3];

  logic [3:0]  dA;  logic [0:0] fA; logic [1:0] chA; logic validA, wrapA;
  logic [11:0] dB;  logic [3:0] fB; logic [1:0] chB; logic validB, wrapB;
  logic [31:0] dC;  logic [7:0] fC; logic [1:0] chC; logic validC, wrapC;

  assign dA = dv[0][3:0];
  assign dB = dv[1][11:0];
  assign dC = dv[2][31:0];

  mux_scan_n #(.N_CH(4), .W(1), .SEL_W(2), .DWELL(5)) u_a (
    .clk(clk), .rst(rst), .d(dA), .sel(sel), .mode(mode), .en(en),
    .f(fA), .ch(chA), .valid(validA), .wrap(wrapA));
  mux_scan_n #(.N_CH(3), .W(4), .SEL_W(2), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .d(dB), .sel(sel), .mode(mode), .en(en),
    .f(fB), .ch(chB), .valid(validB), .wrap(wrapB));
  mux_scan_n #(.N_CH(4), .W(8), .SEL_W(2), .DWELL(1)) u_c (
    .clk(clk), .rst(rst), .d(dC), .sel(sel), .mode(mode), .en(en),
    .f(fC), .ch(chC), .valid(validC), .wrap(wrapC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: scan position kept as one phase number in [0, N_CH*DWELL).
  int nch [3] = '{4, 3, 4};
  int dw  [3] = '{5, 3, 1};
  int wd  [3] = '{1, 4, 8};
  int m_state [3];  // 0 idle, 1 static, 2 scan
  int m_phase [3];
  int m_f [3], m_ch [3], m_valid [3], m_wrap [3];

  function automatic int chval(int k, int idx);
    logic [63:0] mask;
    mask = (64'd1 << wd[k]) - 64'd1;
    return int'((dv[k] >> (idx * wd[k])) & mask);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = 0; m_phase[k] = 0;
      m_f[k] = 0; m_ch[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int s, inr, st;
      s   = int'(sel);
      inr = (s < nch[k]) ? 1 : 0;
      if (rst) begin
        m_state[k] = 0; m_phase[k] = 0;
        m_f[k] = 0; m_ch[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
      end else if (!en) begin
        m_state[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
      end else if (!mode) begin
        m_state[k] = 1; m_ch[k] = s; m_valid[k] = inr; m_wrap[k] = 0;
        m_f[k] = inr ? chval(k, s) : 0;
      end else if (m_state[k] == 1) begin
        st = inr ? s : 0;
        m_phase[k] = st * dw[k];
        m_state[k] = 2; m_ch[k] = st; m_f[k] = chval(k, st);
        m_valid[k] = 1; m_wrap[k] = 0;
      end else begin
        m_phase[k] = (m_phase[k] + 1) % (nch[k] * dw[k]);
        m_state[k] = 2; m_ch[k] = m_phase[k] / dw[k];
        m_f[k] = chval(k, m_ch[k]); m_valid[k] = 1;
        m_wrap[k] = (m_phase[k] == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic model_chk();
    chk("model_a_f", int'(fA), m_f[0]);       chk("model_a_ch", int'(chA), m_ch[0]);
    chk("model_a_valid", int'(validA), m_valid[0]); chk("model_a_wrap", int'(wrapA), m_wrap[0]);
    chk("model_b_f", int'(fB), m_f[1]);       chk("model_b_ch", int'(chB), m_ch[1]);
    chk("model_b_valid", int'(validB), m_valid[1]); chk("model_b_wrap", int'(wrapB), m_wrap[1]);
    chk("model_c_f", int'(fC), m_f[2]);       chk("model_c_ch", int'(chC), m_ch[2]);
    chk("model_c_valid", int'(validC), m_valid[2]); chk("model_c_wrap", int'(wrapC), m_wrap[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_chk();
  endtask

  task automatic rand_data();
    for (int k = 0; k < 3; k++) dv[k] = {$urandom, $urandom};
  endtask

  typedef struct {
    logic [1:0] sel; logic mode; logic en; logic [3:0] d;
    logic f; logic [1:0] ch; logic valid; logic wrap;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int exp_ch, lastf;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0;
    rand_data();
    model_reset();

    // Reset held with arbitrary inputs.
    for (int i = 0; i < 3; i++) begin
      rand_data(); sel = 2'($urandom_range(0, 3)); en = 1'b1;
      tick();
      chk("rst_f", int'(fA), 0);       chk("rst_ch", int'(chA), 0);
      chk("rst_valid", int'(validA), 0); chk("rst_wrap", int'(wrapA), 0);
    end
    rst = 1'b0;

    // Static-select table on the 4:1, 1-bit instance.
    tbl[0] = '{2'd0, 1'b0, 1'b1, 4'b1010, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[1] = '{2'd1, 1'b0, 1'b1, 4'b1010, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[2] = '{2'd2, 1'b0, 1'b1, 4'b1010, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[3] = '{2'd3, 1'b0, 1'b1, 4'b1010, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[4] = '{2'd3, 1'b0, 1'b1, 4'b0101, 1'b0, 2'd3, 1'b1, 1'b0};
    tbl[5] = '{2'd1, 1'b0, 1'b1, 4'b0101, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[6] = '{2'd2, 1'b0, 1'b0, 4'b1111, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[7] = '{2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 2'd2, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rand_data();
      dv[0] = {60'd0, tbl[i].d};
      sel = tbl[i].sel; mode = tbl[i].mode; en = tbl[i].en;
      tick();
      chk("tbl_f", int'(fA), int'(tbl[i].f));
      chk("tbl_ch", int'(chA), int'(tbl[i].ch));
      chk("tbl_valid", int'(validA), int'(tbl[i].valid));
      chk("tbl_wrap", int'(wrapA), int'(tbl[i].wrap));
    end

    // Scan from channel 1 on the DWELL=5 instance, up to mid channel 2 dwell.
    sel = 2'd1; mode = 1'b0; en = 1'b1;
    tick();
    mode = 1'b1;
    lastf = 0;
    for (int i = 0; i < 27; i++) begin
      rand_data();
      tick();
      exp_ch = (1 + i / 5) % 4;
      chk("scan_ch", int'(chA), exp_ch);
      chk("scan_f", int'(fA), chval(0, exp_ch));
      chk("scan_valid", int'(validA), 1);
      chk("scan_wrap", int'(wrapA), (i == 15) ? 1 : 0);
      lastf = chval(0, exp_ch);
    end

    // Enable freeze in channel 2, then resume the remaining dwell.
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rand_data();
      tick();
      chk("frz_valid", int'(validA), 0);
      chk("frz_ch", int'(chA), 2);
      chk("frz_f", int'(fA), lastf);
      chk("frz_wrap", int'(wrapA), 0);
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      tick();
      exp_ch = (i < 3) ? 2 : 3;
      chk("resume_ch", int'(chA), exp_ch);
      chk("resume_f", int'(fA), chval(0, exp_ch));
      chk("resume_wrap", int'(wrapA), 0);
    end

    // Scan to static switch while on channel 3.
    mode = 1'b0; sel = 2'd0; rand_data();
    tick();
    chk("sw_ch", int'(chA), 0);
    chk("sw_f", int'(fA), chval(0, 0));
    chk("sw_wrap", int'(wrapA), 0);
    chk("sw_valid", int'(validA), 1);

    // DWELL=1 instance: channel changes every cycle, wrap every 4 cycles.
    mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rand_data();
      tick();
      chk("dw1_ch", int'(chC), i % 4);
      chk("dw1_f", int'(fC), chval(2, i % 4));
      chk("dw1_wrap", int'(wrapC), (i > 0 && i % 4 == 0) ? 1 : 0);
    end

    // Out-of-range select on the 3-channel instance.
    mode = 1'b0; sel = 2'd3; rand_data();
    tick();
    chk("oor_valid", int'(validB), 0);
    chk("oor_f", int'(fB), 0);
    chk("oor_ch", int'(chB), 3);
    sel = 2'd2; rand_data();
    tick();
    chk("inr_valid", int'(validB), 1);
    chk("inr_f", int'(fB), chval(1, 2));
    sel = 2'd3; mode = 1'b1; rand_data();
    tick();
    chk("oor_scan_ch", int'(chB), 0);
    chk("oor_scan_valid", int'(validB), 1);

    // Random controls and data against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = 2'($urandom_range(0, 3));
      rand_data();
      tick();
    end
    rst = 1'b0;

    // Asynchronous reset between edges.
    en = 1'b1; mode = 1'b0; sel = 2'd1; dv[0] = 64'd2;
    tick();
    chk("pre_arst_f", int'(fA), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_f", int'(fA), 0);       chk("arst_ch", int'(chA), 0);
    chk("arst_valid", int'(validA), 0); chk("arst_wrap", int'(wrapA), 0);
    model_reset();
    tick();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
